// File: rtl/ioctl_upload_server.sv
// HPS upload responder: pauses the core CPU, then serves HPS byte reads
// from a core RAM port, stretching each in-range read with ioctl_wait.
module ioctl_upload_server #(
   parameter int          ADDR_W  = 10,
   parameter int          SIZE    = 1024,
   parameter int          RAM_LAT = 1,
   parameter logic [7:0]  FILL    = 8'hFF
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_upload,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic              pause_req,
   input  logic              pause_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   input  logic [7:0]        ram_q,
   output logic              upload_active,
   output logic [15:0]       byte_count
);

   typedef enum logic [1:0] {
      IDLE,
      PAUSE,
      READY,
      FETCH
   } state_t;

   state_t              state_q;
   logic [2:0]          lat_q;
   logic [7:0]          din_q;
   logic                wait_q;
   logic                pause_req_q;
   logic [ADDR_W-1:0]   ram_addr_q;
   logic                ram_rd_q;
   logic                active_q;
   logic [15:0]         count_q;

   logic                in_range;
   logic [15:0]         count_d;

   // Only the full-width compare decides range; upper bits never alias.
   assign in_range = ({7'd0, ioctl_addr} < 32'(SIZE));
   assign count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= IDLE;
         lat_q       <= '0;
         din_q       <= '0;
         wait_q      <= 1'b0;
         pause_req_q <= 1'b0;
         ram_addr_q  <= '0;
         ram_rd_q    <= 1'b0;
         active_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         ram_rd_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (ioctl_upload) begin
                  state_q     <= PAUSE;
                  pause_req_q <= 1'b1;
                  wait_q      <= 1'b1;
                  active_q    <= 1'b1;
                  count_q     <= '0;
               end
            end
            PAUSE: begin
               if (!ioctl_upload) begin
                  state_q     <= IDLE;
                  pause_req_q <= 1'b0;
                  wait_q      <= 1'b0;
                  active_q    <= 1'b0;
               end else if (pause_ack) begin
                  state_q <= READY;
                  wait_q  <= 1'b0;
               end
            end
            READY: begin
               if (!ioctl_upload) begin
                  state_q     <= IDLE;
                  pause_req_q <= 1'b0;
                  active_q    <= 1'b0;
               end else if (ioctl_rd) begin
                  if (in_range) begin
                     state_q    <= FETCH;
                     ram_addr_q <= ioctl_addr[ADDR_W-1:0];
                     ram_rd_q   <= 1'b1;
                     wait_q     <= 1'b1;
                     lat_q      <= '0;
                  end else begin
                     din_q   <= FILL;
                     count_q <= count_d;
                  end
               end
            end
            FETCH: begin
               // Reads arriving here are protocol violations and dropped.
               if (lat_q == 3'(RAM_LAT)) begin
                  state_q <= READY;
                  din_q   <= ram_q;
                  wait_q  <= 1'b0;
                  count_q <= count_d;
               end else begin
                  lat_q <= lat_q + 3'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ioctl_din     = din_q;
   assign ioctl_wait    = wait_q;
   assign pause_req     = pause_req_q;
   assign ram_addr      = ram_addr_q;
   assign ram_rd        = ram_rd_q;
   assign upload_active = active_q;
   assign byte_count    = count_q;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Scoreboarded bench for ioctl_upload_server with a RAM_LAT=2 RAM model.
module tb_ioctl_upload_server;

   localparam int LAT = 2;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_upload = 1'b0;
   logic        ioctl_rd = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        pause_req;
   logic        pause_ack = 1'b0;
   logic [9:0]  ram_addr;
   logic        ram_rd;
   logic [7:0]  ram_q;
   logic        upload_active;
   logic [15:0] byte_count;

   int n_cmp = 0;
   int n_bad = 0;
   int n_rd  = 0;

   logic [7:0] mem [1024];
   logic [7:0] pipe [LAT];
   logic [7:0] exp_q [$];

   ioctl_upload_server #(
      .ADDR_W(10), .SIZE(1024), .RAM_LAT(LAT), .FILL(8'hFF)
   ) u_dut (
      .clk_sys(clk_sys), .reset(reset),
      .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
      .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
      .ioctl_wait(ioctl_wait), .pause_req(pause_req),
      .pause_ack(pause_ack), .ram_addr(ram_addr),
      .ram_rd(ram_rd), .ram_q(ram_q),
      .upload_active(upload_active), .byte_count(byte_count)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      pipe[0] <= mem[ram_addr];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign ram_q = pipe[LAT-1];

   always @(negedge clk_sys) if (ram_rd) n_rd++;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      @(negedge clk_sys);
   endtask

   task automatic open_session();
      ioctl_upload = 1'b1;
      pause_ack = 1'b0;
      step();
      step();
      pause_ack = 1'b1;
      step();
      check("open_wait", ioctl_wait, 0);
      check("open_active", upload_active, 1);
   endtask

   task automatic do_read(input logic [24:0] a);
      int hc;
      logic inr;
      inr = (a < 25'd1024);
      exp_q.push_back(inr ? mem[a[9:0]] : 8'hFF);
      ioctl_addr = a;
      ioctl_rd = 1'b1;
      step();
      ioctl_rd = 1'b0;
      if (inr) begin
         check("ram_rd", ram_rd, 1);
         check("ram_addr", ram_addr, a[9:0]);
         hc = 0;
         while (ioctl_wait && hc < 20) begin
            hc++;
            step();
            if (hc == 1) check("rd_pulse", ram_rd, 0);
         end
         check("wait_len", hc, LAT + 1);
      end else begin
         check("oor_wait", ioctl_wait, 0);
         check("oor_ram_rd", ram_rd, 0);
      end
      check("rdata", ioctl_din, exp_q.pop_front());
   endtask

   initial begin
      int hc;
      int rd0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      mem[10'h012] = 8'hA5;
      mem[10'h055] = 8'h3C;
      mem[10'h077] = 8'h5A;

      step();
      step();
      check("rst_din", ioctl_din, 0);
      check("rst_wait", ioctl_wait, 0);
      check("rst_pause", pause_req, 0);
      check("rst_ram_rd", ram_rd, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_count", byte_count, 0);
      check("rst_active", upload_active, 0);
      reset = 1'b0;

      // Session open: ack arrives after wait has been high six cycles.
      ioctl_upload = 1'b1;
      step();
      check("pause_req", pause_req, 1);
      check("open_active", upload_active, 1);
      hc = 0;
      for (int i = 0; i < 6; i++) begin
         if (ioctl_wait) hc++;
         if (i < 5) step();
      end
      pause_ack = 1'b1;
      step();
      check("pause_wait_len", hc, 6);
      check("ready_wait", ioctl_wait, 0);
      check("ready_pause", pause_req, 1);

      do_read(25'h012);
      check("count_1", byte_count, 1);

      rd0 = n_rd;
      do_read(25'h400);
      do_read(25'h1000400);
      check("oor_no_rd", n_rd - rd0, 0);
      check("count_3", byte_count, 3);

      // A read pulsed during FETCH is dropped, not queued.
      rd0 = n_rd;
      exp_q.push_back(mem[10'h077]);
      ioctl_addr = 25'h077;
      ioctl_rd = 1'b1;
      step();
      ioctl_addr = 25'h012;
      step();
      ioctl_rd = 1'b0;
      hc = 0;
      while (ioctl_wait && hc < 20) begin hc++; step(); end
      check("viol_data", ioctl_din, exp_q.pop_front());
      step();
      step();
      check("viol_rd_cnt", n_rd - rd0, 1);
      check("viol_wait", ioctl_wait, 0);
      check("count_4", byte_count, 4);

      // Upload dropped the cycle after ram_rd: data still delivered.
      exp_q.push_back(mem[10'h055]);
      ioctl_addr = 25'h055;
      ioctl_rd = 1'b1;
      step();
      ioctl_rd = 1'b0;
      check("drop_ram_rd", ram_rd, 1);
      hc = 1;
      step();
      ioctl_upload = 1'b0;
      while (ioctl_wait && hc < 20) begin hc++; step(); end
      check("drop_wait_len", hc, LAT + 1);
      check("drop_data", ioctl_din, exp_q.pop_front());
      check("drop_pause_hold", pause_req, 1);
      step();
      check("drop_pause", pause_req, 0);
      check("drop_active", upload_active, 0);

      rd0 = n_rd;
      ioctl_addr = 25'h012;
      ioctl_rd = 1'b1;
      step();
      ioctl_rd = 1'b0;
      step();
      check("idle_din_hold", ioctl_din, mem[10'h055]);
      check("idle_no_rd", n_rd - rd0, 0);

      // Reset landing mid-fetch discards the late RAM byte.
      open_session();
      check("reopen_count", byte_count, 0);
      ioctl_addr = 25'h055;
      ioctl_rd = 1'b1;
      step();
      ioctl_rd = 1'b0;
      reset = 1'b1;
      ioctl_upload = 1'b0;
      step();
      check("mid_din", ioctl_din, 0);
      check("mid_wait", ioctl_wait, 0);
      check("mid_pause", pause_req, 0);
      check("mid_ram_rd", ram_rd, 0);
      check("mid_active", upload_active, 0);
      reset = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         step();
         check("late_din", ioctl_din, 0);
      end

      // Back-to-back sweep of the whole window.
      open_session();
      for (int i = 0; i < 1024; i++) do_read(25'(i));
      check("sweep_count", byte_count, 1024);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
